// File: rtl/lot_pkg.sv
// Shared types and constants for the parking-lot departure path.
// Covers the FSM state encoding, field widths, key bit positions and lot indices.
package lot_pkg;

  localparam int CAPACITY = 15;
  localparam int CNT_W    = 4;

  localparam int KEY_DIG_LO  = 1;
  localparam int KEY_DIG_HI  = 9;
  localparam int KEY_CONFIRM = 10;
  localparam int KEY_CLEAR   = 11;

  typedef logic [1:0] lot_t;

  localparam lot_t LOT1 = 2'd0;
  localparam lot_t LOT2 = 2'd1;
  localparam lot_t LOT3 = 2'd2;
  localparam lot_t LOT4 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    REQ   = 2'd2,
    ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/lot_release_if.sv
// Release handshake toward the occupancy owner: "lot N, k vehicles leave".
interface lot_release_if
  import lot_pkg::*;
();

  logic             rel_valid;
  logic             rel_ready;
  lot_t             rel_lot;
  logic [CNT_W-1:0] rel_amt;

  modport master (output rel_valid, output rel_lot, output rel_amt, input rel_ready);
  modport slave  (input rel_valid, input rel_lot, input rel_amt, output rel_ready);

endinterface

// File: rtl/lot_key_decode.sv
// Combinational decode of lot-select switches (sw1 highest priority) and keypad edges.
module lot_key_decode
  import lot_pkg::*;
(
  input  logic             sw1,
  input  logic             sw2,
  input  logic             sw3,
  input  logic             sw4,
  input  logic [15:0]      key_edge,
  output lot_t             lot,
  output logic             lot_valid,
  output logic [CNT_W-1:0] digit,
  output logic             is_digit,
  output logic             is_confirm,
  output logic             is_clear,
  output logic             multi_hit
);

  logic [10:0] keys;
  logic        any_digit;
  logic        unused_keys;

  assign keys        = key_edge[KEY_CLEAR:KEY_DIG_LO];
  assign unused_keys = ^{key_edge[15:12], key_edge[0]};

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hit  = |(keys & (keys - 11'd1));
  assign any_digit  = |key_edge[KEY_DIG_HI:KEY_DIG_LO];
  assign is_digit   = any_digit && !multi_hit;
  assign is_confirm = key_edge[KEY_CONFIRM] && !multi_hit;
  assign is_clear   = key_edge[KEY_CLEAR] && !multi_hit;

  always_comb begin
    lot       = LOT1;
    lot_valid = 1'b1;
    if (sw1)      lot = LOT1;
    else if (sw2) lot = LOT2;
    else if (sw3) lot = LOT3;
    else if (sw4) lot = LOT4;
    else          lot_valid = 1'b0;
  end

  always_comb begin
    digit = '0;
    for (int i = KEY_DIG_LO; i <= KEY_DIG_HI; i++) begin
      if (key_edge[i]) digit = CNT_W'(i);
    end
  end

endmodule

// File: rtl/lot_release.sv
// Departure FSM: turns a single-digit keypad entry into a validated release request,
// with an error hold timer and an idle-entry timeout.
module lot_release
  import lot_pkg::*;
#(
  parameter int unsigned ERR_CYCLES     = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw1,
  input  logic             sw2,
  input  logic             sw3,
  input  logic             sw4,
  input  logic [15:0]      key_edge,
  input  logic [CNT_W-1:0] rest1,
  input  logic [CNT_W-1:0] rest2,
  input  logic [CNT_W-1:0] rest3,
  input  logic [CNT_W-1:0] rest4,
  lot_release_if.master    rel,
  output logic [CNT_W-1:0] entry_amt,
  output lot_t             entry_lot,
  output logic             err,
  output logic             busy
);

  lot_t             lot;
  logic             lot_valid;
  logic [CNT_W-1:0] digit;
  logic             is_digit, is_confirm, is_clear, multi_hit;

  lot_key_decode u_dec (
    .sw1        (sw1),
    .sw2        (sw2),
    .sw3        (sw3),
    .sw4        (sw4),
    .key_edge   (key_edge),
    .lot        (lot),
    .lot_valid  (lot_valid),
    .digit      (digit),
    .is_digit   (is_digit),
    .is_confirm (is_confirm),
    .is_clear   (is_clear),
    .multi_hit  (multi_hit)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] entry_amt_q, entry_amt_d;
  lot_t             entry_lot_q, entry_lot_d;
  logic             rel_valid_q, rel_valid_d;
  lot_t             rel_lot_q, rel_lot_d;
  logic [CNT_W-1:0] rel_amt_q, rel_amt_d;
  logic             err_q, err_d;
  logic             busy_q;
  logic [31:0]      tmo_q, tmo_d;
  logic [31:0]      errc_q, errc_d;
  logic [CNT_W-1:0] rest_sel;
  logic             unused_multi;

  assign unused_multi = multi_hit;

  always_comb begin
    case (entry_lot_q)
      LOT1:    rest_sel = rest1;
      LOT2:    rest_sel = rest2;
      LOT3:    rest_sel = rest3;
      default: rest_sel = rest4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    entry_amt_d = entry_amt_q;
    entry_lot_d = entry_lot_q;
    rel_valid_d = rel_valid_q;
    rel_lot_d   = rel_lot_q;
    rel_amt_d   = rel_amt_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    errc_d      = errc_q;
    case (state_q)
      IDLE: begin
        if (is_digit && lot_valid) begin
          state_d     = ENTRY;
          entry_lot_d = lot;
          entry_amt_d = digit;
          tmo_d       = '0;
        end
      end
      ENTRY: begin
        // Switch movement away from the latched lot abandons the entry.
        if (!lot_valid || lot != entry_lot_q || is_clear) begin
          state_d     = IDLE;
          entry_amt_d = '0;
        end else if (is_digit) begin
          entry_amt_d = digit;
          tmo_d       = '0;
        end else if (is_confirm) begin
          if (entry_amt_q != '0 && entry_amt_q <= rest_sel) begin
            state_d     = REQ;
            rel_valid_d = 1'b1;
            rel_lot_d   = entry_lot_q;
            rel_amt_d   = entry_amt_q;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            errc_d  = '0;
          end
        end else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          entry_amt_d = '0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      REQ: begin
        if (rel_valid_q && rel.rel_ready) begin
          state_d     = IDLE;
          rel_valid_d = 1'b0;
          entry_amt_d = '0;
        end
      end
      default: begin
        if (is_clear || errc_q == 32'(ERR_CYCLES - 1)) begin
          state_d     = IDLE;
          err_d       = 1'b0;
          entry_amt_d = '0;
        end else begin
          errc_d = errc_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      entry_amt_q <= '0;
      entry_lot_q <= LOT1;
      rel_valid_q <= 1'b0;
      rel_lot_q   <= LOT1;
      rel_amt_q   <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= '0;
      errc_q      <= '0;
    end else begin
      state_q     <= state_d;
      entry_amt_q <= entry_amt_d;
      entry_lot_q <= entry_lot_d;
      rel_valid_q <= rel_valid_d;
      rel_lot_q   <= rel_lot_d;
      rel_amt_q   <= rel_amt_d;
      err_q       <= err_d;
      busy_q      <= (state_d != IDLE);
      tmo_q       <= tmo_d;
      errc_q      <= errc_d;
    end
  end

  assign rel.rel_valid = rel_valid_q;
  assign rel.rel_lot   = rel_lot_q;
  assign rel.rel_amt   = rel_amt_q;
  assign entry_amt     = entry_amt_q;
  assign entry_lot     = entry_lot_q;
  assign err           = err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_lot_release.sv
// Directed bench for lot_release with short error/timeout windows (10 and 20 cycles).
module tb_lot_release;
  import lot_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sw1 = 0, sw2 = 0, sw3 = 0, sw4 = 0;
  logic [15:0]      key_edge = '0;
  logic [CNT_W-1:0] rest1 = '0, rest2 = '0, rest3 = '0, rest4 = '0;
  logic [CNT_W-1:0] entry_amt;
  lot_t             entry_lot;
  logic             err, busy;
  int               vectors = 0;
  int               miscompares = 0;
  int               err_hi;

  lot_release_if rel_if ();

  lot_release #(.ERR_CYCLES(10), .TIMEOUT_CYCLES(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw1       (sw1),
    .sw2       (sw2),
    .sw3       (sw3),
    .sw4       (sw4),
    .key_edge  (key_edge),
    .rest1     (rest1),
    .rest2     (rest2),
    .rest3     (rest3),
    .rest4     (rest4),
    .rel       (rel_if.master),
    .entry_amt (entry_amt),
    .entry_lot (entry_lot),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    key_edge = 16'(1 << k);
    tick();
    key_edge = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rel_if.rel_ready = 1'b0;
    tick();
    chk("rst_valid", 32'(rel_if.rel_valid), 0);
    chk("rst_outs", {entry_amt, entry_lot, err, busy, rel_if.rel_lot, rel_if.rel_amt}, 0);
    rst_n = 1'b1;
    tick();

    // normal release on lot 2
    sw2 = 1; rest2 = 4'd7;
    press(5);
    chk("n_busy", 32'(busy), 1);
    chk("n_entry_amt", 32'(entry_amt), 5);
    chk("n_entry_lot", 32'(entry_lot), 1);
    press(10);
    chk("n_valid", 32'(rel_if.rel_valid), 1);
    chk("n_lot", 32'(rel_if.rel_lot), 1);
    chk("n_amt", 32'(rel_if.rel_amt), 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("n_hold", {rel_if.rel_valid, 6'(rel_if.rel_lot), 8'(rel_if.rel_amt)}, {1'b1, 6'd1, 8'd5});
    end
    rel_if.rel_ready = 1'b1;
    tick();
    rel_if.rel_ready = 1'b0;
    chk("n_acc_valid", 32'(rel_if.rel_valid), 0);
    chk("n_acc_busy", 32'(busy), 0);
    chk("n_acc_amt", 32'(entry_amt), 0);

    // over-release on lot 1: err held 10 cycles
    sw2 = 0; sw1 = 1; rest1 = 4'd3;
    press(4);
    press(10);
    err_hi = 0;
    for (int i = 0; i < 30 && err; i++) begin
      if (rel_if.rel_valid) err_hi = 100;
      err_hi++;
      tick();
    end
    chk("o_err_cycles", err_hi, 10);
    chk("o_err_now", 32'(err), 0);
    chk("o_idle", {busy, 4'(entry_amt)}, 0);

    // boundary: occupancy 0 rejects 1; clear exits ERR immediately
    rest1 = 4'd0;
    press(1);
    press(10);
    chk("z_err", 32'(err), 1);
    press(11);
    chk("z_clear", {err, busy, 4'(entry_amt)}, 0);

    // digit overwrite and clear on lot 3
    sw1 = 0; sw3 = 1;
    press(2);
    press(6);
    chk("d_amt", 32'(entry_amt), 6);
    chk("d_lot", 32'(entry_lot), 2);
    press(11);
    chk("d_clear", {busy, 4'(entry_amt)}, 0);

    // lot change abort on lot 4
    sw3 = 0; sw4 = 1; rest4 = 4'd9;
    press(3);
    chk("a_lot", 32'(entry_lot), 3);
    sw1 = 1;
    tick();
    chk("a_abort", {busy, 4'(entry_amt)}, 0);
    press(10);
    chk("a_confirm_ign", {rel_if.rel_valid, busy}, 0);
    sw1 = 0; sw4 = 0;

    // timeout after 20 idle cycles
    sw2 = 1;
    press(1);
    repeat (19) tick();
    chk("t_still", 32'(busy), 1);
    tick();
    chk("t_out", {busy, 4'(entry_amt)}, 0);

    // multi-key ignored in IDLE and ENTRY
    key_edge = 16'h000C; tick(); key_edge = '0;
    chk("m_idle", {busy, 4'(entry_amt)}, 0);
    press(4);
    key_edge = 16'h000C; tick(); key_edge = '0;
    chk("m_entry", 32'(entry_amt), 4);
    press(11);

    // exact-capacity release, then async reset in REQ
    rest2 = 4'd7;
    press(7);
    press(10);
    chk("r_amt", {rel_if.rel_valid, 8'(rel_if.rel_amt)}, {1'b1, 8'd7});
    rest2 = 4'd0;
    press(11);
    tick();
    chk("r_hold", {rel_if.rel_valid, 8'(rel_if.rel_amt), busy}, {1'b1, 8'd7, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("r_rst_valid", 32'(rel_if.rel_valid), 0);
    chk("r_rst_outs", {entry_amt, entry_lot, err, busy, rel_if.rel_lot, rel_if.rel_amt}, 0);
    rst_n = 1'b1;
    tick();
    rest2 = 4'd7;
    press(10);
    chk("r_post_confirm", {rel_if.rel_valid, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lot_release.md
Name: lot_release

Overview:
- Departure side of the parking-lot manager: converts keypad departures into release requests that return spaces to a lot.
- Release requests have the form "lot N, k vehicles leave".
- Takes the same lot-select switches and debounced key edges as the admission block.
- Validates the request against the lot's current occupancy and issues a valid/ready release request to the occupancy owner.

Parameters:
- CAPACITY, 15, spaces per lot; occupancy range 0..CAPACITY.
- CNT_W, 4, width of occupancy/amount fields.
- ERR_CYCLES, 50_000_000, cycles the err flag is held after a rejected request.
- TIMEOUT_CYCLES, 500_000_000, idle cycles in ENTRY before the entry is abandoned.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sw1  in  1  lot 1 select (highest priority)
- sw2  in  1  lot 2 select
- sw3  in  1  lot 3 select
- sw4  in  1  lot 4 select (lowest priority)
- key_edge  in  16  one-cycle key pulses; [9:1]=digits 1..9, [10]=confirm, [11]=clear, others ignored
- rest1  in  CNT_W  current occupancy of lot 1
- rest2  in  CNT_W  current occupancy of lot 2
- rest3  in  CNT_W  current occupancy of lot 3
- rest4  in  CNT_W  current occupancy of lot 4
- rel_ready  in  1  occupancy owner accepts the release this cycle
- rel_valid  out  1  release request pending
- rel_lot  out  2  lot index 0..3 (lot1=0)
- rel_amt  out  CNT_W  vehicles leaving
- entry_amt  out  CNT_W  digit currently typed (for display)
- entry_lot  out  2  lot latched for the current entry
- err  out  1  rejected-request indicator
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output = 0; timers = 0. Reset mid-REQ drops rel_valid immediately; no release is issued.
- Lot decode: priority sw1>sw2>sw3>sw4. If no switch is on, there is no lot and all keys are ignored in IDLE.
- Key validity: a cycle with more than one bit set in key_edge[11:1] is ignored entirely.
- IDLE:
  - Digit d with a lot selected -> ENTRY; entry_lot <= decoded lot, entry_amt <= d.
  - Confirm and clear are ignored.
- ENTRY:
  - Digit d: entry_amt <= d; the last digit wins (single digit only); timeout timer restarts.
  - Clear: -> IDLE; entry_amt <= 0.
  - Decoded lot differs from entry_lot, or no lot is selected: abort -> IDLE; entry_amt <= 0.
  - Timer reaches TIMEOUT_CYCLES-1 with no key: -> IDLE; entry_amt <= 0.
  - Confirm: the check is evaluated in the same cycle against rest[entry_lot].
    - entry_amt >= 1 and entry_amt <= rest[entry_lot]: -> REQ; rel_lot <= entry_lot; rel_amt <= entry_amt; rel_valid <= 1 on the next cycle.
    - Otherwise: -> ERR; err <= 1.
- REQ:
  - rel_valid, rel_lot and rel_amt are held stable until rel_ready is sampled high while rel_valid=1.
  - On acceptance, in the same edge: rel_valid <= 0; entry_amt <= 0; -> IDLE.
  - All keys and switch changes are ignored while in REQ.
  - rel_ready high while rel_valid=0 has no effect.
- ERR:
  - err held for exactly ERR_CYCLES cycles, then err <= 0, entry_amt <= 0, -> IDLE.
  - Keys are ignored, except clear, which exits immediately (err <= 0).
- Occupancy inputs are sampled only at the confirm cycle. Later changes to them do not affect a pending REQ.
- Arithmetic: comparisons are unsigned CNT_W. No wrap is possible because rel_amt <= rest <= CAPACITY.
- busy = (state != IDLE), registered.

Decomposition:
- Shared package lot_pkg holds:
  - state enum {IDLE, ENTRY, REQ, ERR};
  - CAPACITY and CNT_W;
  - key index constants KEY_CONFIRM=10, KEY_CLEAR=11, KEY_DIG_LO=1, KEY_DIG_HI=9;
  - lot index constants.
- One sub-module, lot_key_decode (combinational):
  - sw1..sw4 -> lot index + lot_valid;
  - key_edge -> digit value, is_digit, is_confirm, is_clear, multi_hit.
- The FSM and the two timers stay in lot_release.

Test Plan:
- Normal release: sw2=1, rest2=7; press digit 5, then confirm -> rel_valid=1, rel_lot=1, rel_amt=5 one cycle after confirm; rel_ready held 0 for 3 cycles -> outputs stable; rel_ready=1 -> rel_valid=0 next cycle; busy=0.
- Over-release: sw1=1, rest1=3; press digit 4, then confirm -> err=1 for exactly ERR_CYCLES (bench uses 10); no rel_valid; return to IDLE with entry_amt=0.
- Digit overwrite and clear: sw3=1; press 2 then 6 -> entry_amt=6; press clear -> IDLE, entry_amt=0, busy=0.
- Lot change abort: sw4=1; press 3; raise sw1 -> abort to IDLE; subsequent confirm is ignored; rel_valid stays 0.
- Timeout and multi-key: TIMEOUT_CYCLES=20; press 1, then no keys for 20 cycles -> IDLE. Separately, key_edge bits 2 and 3 pulsed together -> no state change.
- Async reset in REQ: rel_valid=1, then rst_n pulsed low mid-cycle -> rel_valid=0 and all outputs 0 immediately; after release, confirm is ignored until a digit is entered.
